// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer with a fixed number of wait states, a local
// byte-wide register file and PSLVERR reporting for out-of-range addresses
// and access phases that arrive without a setup phase.
// Optional feature macro: APB_WAIT_SLV_WPROT_EN (location DEPTH-1 becomes a
// write-protect register; bit0=1 blocks writes to 0..DEPTH-2).
module apb_wait_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, wdata_q;
    logic       wr_q;
    logic [7:0] mem [DEPTH];

    logic       latch, enter_rdy, proto_err, err, mem_we;
    logic       eff_wr, in_range, wp_err;
    logic [7:0] eff_addr, rd_val;
    logic [7:0] prdata_d;
    logic       pready_d, pslverr_d;

`ifdef APB_WAIT_SLV_WPROT_EN
    logic [7:0] wp_q;
`endif

    // With zero wait states READY is entered on the setup edge itself, so the
    // address/direction come straight off the bus; otherwise use the latched copy.
    always_comb begin
        eff_addr = (state_q == IDLE) ? PADDR  : addr_q;
        eff_wr   = (state_q == IDLE) ? PWRITE : wr_q;
        in_range = ({1'b0, eff_addr} < 9'(DEPTH));
`ifdef APB_WAIT_SLV_WPROT_EN
        wp_err   = eff_wr && wp_q[0] && ({1'b0, eff_addr} < 9'(DEPTH - 1));
        rd_val   = (eff_addr == 8'(DEPTH - 1)) ? wp_q : mem[eff_addr[AW-1:0]];
`else
        wp_err   = 1'b0;
        rd_val   = mem[eff_addr[AW-1:0]];
`endif
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        enter_rdy = 1'b0;
        proto_err = 1'b0;
        mem_we    = 1'b0;
        pready_d  = PREADY;
        pslverr_d = PSLVERR;
        prdata_d  = PRDATA;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch = 1'b1;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) enter_rdy = 1'b1;
                    else                  state_d   = WAIT;
                end else if (PSEL && PENABLE) begin
                    // access phase with no setup: answer with an error, touch nothing
                    enter_rdy = 1'b1;
                    proto_err = 1'b1;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) enter_rdy = 1'b1;
                end
            end
            READY: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (PENABLE) begin
                    // completion edge: PSLVERR already carries this transfer's error
                    mem_we    = wr_q && !PSLVERR;
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        err = proto_err || !in_range || wp_err;
        if (enter_rdy) begin
            state_d   = READY;
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = err;
            if (err)          prdata_d = 8'h00;
            else if (!eff_wr) prdata_d = rd_val;
        end
    end

    // State, counter, setup-phase capture and bus outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            PRDATA  <= prdata_d;
            if (latch) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                wr_q    <= PWRITE;
            end
        end
    end

    // Storage array, not reset; a reset on the completion edge drops the write.
    always_ff @(posedge PCLK) begin
        if (mem_we && !PRESET) mem[addr_q[AW-1:0]] <= wdata_q;
    end

`ifdef APB_WAIT_SLV_WPROT_EN
    // Write-protect register shadowing the top location.
    always_ff @(posedge PCLK) begin
        if (PRESET)                                      wp_q <= 8'h00;
        else if (mem_we && addr_q == 8'(DEPTH - 1))      wp_q <= wdata_q;
    end
`endif

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

APB completer with a parameterized wait-state counter, a local register file and address-range error reporting. It sits on the slave side of the APB bridge: one instance per PSEL line, replacing the zero-wait behavioural slaves. It exercises the bridge's PREADY stall path and its PSLVERR path with real, registered timing.

## Interface
Parameters:
- DEPTH, 64: number of 8-bit storage locations. Valid addresses are 0..DEPTH-1; DEPTH ≤ 256.
- WAIT_CYCLES, 2: number of access-phase cycles with PREADY low before PREADY rises; range 0..15.

Ports:
- PCLK  input  1  rising-edge clock.
- PRESET  input  1  synchronous, active-high reset (the codebase's active-low PRESETn, inverted at the instantiation).
- PSEL  input  1  slave select from the bridge.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  byte address (the bridge's PADDR[7:0]).
- PWDATA  input  8  write data.
- PRDATA  output  8  registered read data.
- PREADY  output  1  registered transfer-complete.
- PSLVERR  output  1  registered error, valid only while PREADY=1.

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE, sampled PSEL=1 and PENABLE=0 (setup phase): latch PADDR, PWRITE and PWDATA. Load cnt = WAIT_CYCLES.
  - If WAIT_CYCLES=0, go to READY.
  - Otherwise, go to WAIT.
- IDLE, sampled PSEL=1 and PENABLE=1 without a prior setup phase: protocol error. Go to READY with the error flag set; no memory access.
- WAIT, each edge with PSEL=1 and PENABLE=1: cnt decrements. At the edge where cnt=1, go to READY.
- Entering READY: assert PREADY.
  - Error flag = latched address ≥ DEPTH, or a protocol error.
  - Read without error: PRDATA ← mem[addr].
  - Any error: PRDATA ← 0 and PSLVERR ← 1.
- READY, sampled PSEL=1, PENABLE=1, PREADY=1 (completion edge):
  - Write without error: commit mem[addr] ← latched PWDATA.
  - Deassert PREADY and PSLVERR; PRDATA holds its value.
  - Go to IDLE.
- Back-to-back: a new setup phase in the cycle right after completion is accepted from IDLE with no bubble.
- Abort: PSEL sampled 0 in WAIT or READY → go to IDLE. PREADY and PSLVERR are 0 on the next edge, and no write occurs.
- Memory contents are not reset. Reads of never-written locations return X in simulation.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=8'h00, FSM in IDLE, cnt=0.
- Reset sampled mid-transfer: outputs take their reset values on that edge, and any pending write is dropped.
- Setup at cycle T0, first access cycle at T1. PREADY is high during cycle T1+WAIT_CYCLES, for exactly one cycle.
- Total transfer length is 2+WAIT_CYCLES cycles.
- PRDATA and PSLVERR are valid in the same cycle as PREADY.
- A write becomes visible to a read whose READY cycle follows the write's completion edge.
- PADDR, PWRITE and PWDATA changing during the access phase are ignored; only the setup-phase values are used.

## Configuration
- APB_WAIT_SLV_WPROT_EN defined:
  - Location DEPTH-1 is a write-protect register, reset to 8'h00.
  - When bit0=1, writes to addresses 0..DEPTH-2 complete with PSLVERR=1 and no memory update.
  - Location DEPTH-1 itself is always writable and readable.
- Not defined: DEPTH-1 is ordinary storage and no write protection exists.

## Test plan
- Write 8'hA5 to address 8'h10 with WAIT_CYCLES=2, then read 8'h10:
  - Each transfer lasts 4 cycles, with PREADY high only in its 4th cycle.
  - The read returns PRDATA=8'hA5 with PSLVERR=0.
- WAIT_CYCLES=0: a write of 8'h3C to 8'h00 followed back-to-back by a read of 8'h00 → each transfer takes 2 cycles, and the read returns 8'h3C.
- Read of address 8'h40 with DEPTH=64 → PREADY=1, PSLVERR=1, PRDATA=8'h00.
- Write 8'hFF to 8'h45, then read 8'h05 (previously written 8'h11) → the read returns 8'h11, so the out-of-range write did not alias into memory.
- PSEL dropped in the 2nd wait cycle of a write of 8'h77 to 8'h20 → PREADY is never asserted, and a later read of 8'h20 returns the old value. PRESET pulsed during a wait cycle → PREADY=0, PSLVERR=0, PRDATA=8'h00 on the next edge.
- With APB_WAIT_SLV_WPROT_EN: write 8'h01 to 8'h3F, then write 8'h99 to 8'h02 → PSLVERR=1, and reading 8'h02 returns its prior value. Write 8'h00 to 8'h3F, then repeat the write to 8'h02 → PSLVERR=0 and the data is stored.
